// File: rtl/sync_fifo_flags_if.sv
// Write/read handshake, status flags and error controls of sync_fifo_flags.
// The FIFO takes the slave view; the producer/consumer side takes the master view.
interface sync_fifo_flags_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 4
);
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_en;
   logic                  full;
   logic                  almost_full;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  empty;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   level;
   logic                  overflow;
   logic                  underflow;
   logic                  clr_err;

   modport master (
      output wr_data,
      output wr_en,
      output rd_en,
      output clr_err,
      input  full,
      input  almost_full,
      input  rd_data,
      input  rd_valid,
      input  empty,
      input  almost_empty,
      input  level,
      input  overflow,
      input  underflow
   );

   modport slave (
      input  wr_data,
      input  wr_en,
      input  rd_en,
      input  clr_err,
      output full,
      output almost_full,
      output rd_data,
      output rd_valid,
      output empty,
      output almost_empty,
      output level,
      output overflow,
      output underflow
   );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with first-word-fall-through or registered read, programmable
// almost-full/almost-empty thresholds, fill level and sticky overflow/underflow flags.
module sync_fifo_flags #(
   parameter int unsigned DATA_WIDTH    = 16,
   parameter int unsigned ADDR_WIDTH    = 4,
   parameter bit          FWFT          = 1'b1,
   parameter int unsigned AFULL_THRESH  = 12,
   parameter int unsigned AEMPTY_THRESH = 2
) (
   input logic              clk,
   input logic              rst,
   sync_fifo_flags_if.slave fifo
);
   localparam int unsigned Depth  = 2 ** ADDR_WIDTH;
   localparam int unsigned LevelW = ADDR_WIDTH + 1;

   if (DATA_WIDTH < 1) begin : g_bad_data_width
      $error("sync_fifo_flags: DATA_WIDTH must be at least 1");
   end
   if (ADDR_WIDTH < 1 || ADDR_WIDTH > 30) begin : g_bad_addr_width
      $error("sync_fifo_flags: ADDR_WIDTH must be in 1..30");
   end
   if (AFULL_THRESH < 1 || AFULL_THRESH > Depth) begin : g_bad_afull
      $error("sync_fifo_flags: AFULL_THRESH must be in 1..2**ADDR_WIDTH");
   end
   if (AEMPTY_THRESH > Depth - 1) begin : g_bad_aempty
      $error("sync_fifo_flags: AEMPTY_THRESH must be in 0..2**ADDR_WIDTH-1");
   end

   // One extra pointer bit tells full from empty when the address bits match.
   logic [LevelW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [LevelW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] mem_q [Depth];
   logic [LevelW-1:0]     level;
   logic                  full;
   logic                  empty;
   logic                  wr_accept;
   logic                  rd_accept;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;

   always_comb begin
      level     = wr_ptr_q - rd_ptr_q;
      full      = (level == LevelW'(Depth));
      empty     = (level == '0);
      wr_accept = fifo.wr_en && !full;
      rd_accept = fifo.rd_en && !empty;
      wr_ptr_d  = wr_ptr_q + LevelW'(wr_accept);
      rd_ptr_d  = rd_ptr_q + LevelW'(rd_accept);

      // A new error event outranks a clear arriving in the same cycle.
      overflow_d  = overflow_q && !fifo.clr_err;
      underflow_d = underflow_q && !fifo.clr_err;
      if (fifo.wr_en && full) begin
         overflow_d = 1'b1;
      end
      if (fifo.rd_en && empty) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage carries no reset; stale words are never exposed because flags gate them.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= fifo.wr_data;
      end
   end

   assign fifo.level        = level;
   assign fifo.full         = full;
   assign fifo.empty        = empty;
   assign fifo.almost_full  = (level >= LevelW'(AFULL_THRESH));
   assign fifo.almost_empty = (level <= LevelW'(AEMPTY_THRESH));
   assign fifo.overflow     = overflow_q;
   assign fifo.underflow    = underflow_q;

   if (FWFT) begin : g_fwft
      assign fifo.rd_data  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
      assign fifo.rd_valid = !empty;
   end else begin : g_reg_read
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            rd_valid_q <= rd_accept;
            if (rd_accept) begin
               rd_data_q <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
            end
         end
      end

      assign fifo.rd_data  = rd_data_q;
      assign fifo.rd_valid = rd_valid_q;
   end

   level_in_range_a : assert property (@(posedge clk) disable iff (rst)
      level <= LevelW'(Depth));

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives an FWFT and a registered-read sync_fifo_flags with identical stimulus and
// compares both against a queue-based model of the FIFO rules.
module tb_sync_fifo_flags;
   localparam int unsigned DW = 16;
   localparam int unsigned AW = 4;
   localparam int unsigned D  = 16;
   localparam int unsigned AF = 12;
   localparam int unsigned AE = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic          clr_err = 1'b0;

   sync_fifo_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_ft ();
   sync_fifo_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_rr ();

   assign if_ft.wr_data = wr_data;
   assign if_ft.wr_en   = wr_en;
   assign if_ft.rd_en   = rd_en;
   assign if_ft.clr_err = clr_err;
   assign if_rr.wr_data = wr_data;
   assign if_rr.wr_en   = wr_en;
   assign if_rr.rd_en   = rd_en;
   assign if_rr.clr_err = clr_err;

   sync_fifo_flags #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b1),
      .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
   ) dut_ft (
      .clk (clk),
      .rst (rst),
      .fifo(if_ft)
   );

   sync_fifo_flags #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1'b0),
      .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
   ) dut_rr (
      .clk (clk),
      .rst (rst),
      .fifo(if_rr)
   );

   always #5 clk = ~clk;

   // Reference model: contents as a queue, plus the registered-read output state.
   logic [DW-1:0] m_q[$];
   logic          m_ovf = 1'b0;
   logic          m_unf = 1'b0;
   logic          m_rv = 1'b0;
   logic [DW-1:0] m_rd = '0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic          we;
      logic [DW-1:0] wd;
      logic          re;
      logic          ce;
      int            lvl;
      logic          ae;
      logic          ovf;
      logic          unf;
      logic          ft_chk;
      logic [DW-1:0] ft_data;
      logic          rv;
      logic [DW-1:0] rr_data;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rv  = 1'b0;
      m_rd  = '0;
   endtask

   task automatic model_clock(input logic we, input logic [DW-1:0] wd, input logic re,
                              input logic ce);
      bit was_full, was_empty;
      was_full  = (m_q.size() == D);
      was_empty = (m_q.size() == 0);
      m_rv = 1'b0;
      if (re && !was_empty) begin
         m_rd = m_q.pop_front();
         m_rv = 1'b1;
      end
      if (we && !was_full) m_q.push_back(wd);
      if (ce) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
      if (we && was_full) m_ovf = 1'b1;
      if (re && was_empty) m_unf = 1'b1;
   endtask

   task automatic chk_flags(input string tag, input logic [AW:0] lvl, input logic fl,
                            input logic em, input logic af, input logic ae,
                            input logic ovf, input logic unf);
      int n;
      n = m_q.size();
      chk({tag, "_level"}, lvl, n);
      chk({tag, "_full"}, fl, n == D);
      chk({tag, "_empty"}, em, n == 0);
      chk({tag, "_almost_full"}, af, n >= AF);
      chk({tag, "_almost_empty"}, ae, n <= AE);
      chk({tag, "_overflow"}, ovf, m_ovf);
      chk({tag, "_underflow"}, unf, m_unf);
   endtask

   task automatic check_all();
      chk_flags("ft", if_ft.level, if_ft.full, if_ft.empty, if_ft.almost_full,
                if_ft.almost_empty, if_ft.overflow, if_ft.underflow);
      chk_flags("rr", if_rr.level, if_rr.full, if_rr.empty, if_rr.almost_full,
                if_rr.almost_empty, if_rr.overflow, if_rr.underflow);
      chk("ft_rd_valid", if_ft.rd_valid, m_q.size() != 0);
      if (m_q.size() != 0) chk("ft_rd_data", if_ft.rd_data, m_q[0]);
      chk("rr_rd_valid", if_rr.rd_valid, m_rv);
      chk("rr_rd_data", if_rr.rd_data, m_rd);
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step(input logic we, input logic [DW-1:0] wd, input logic re,
                       input logic ce);
      wr_en   = we;
      wr_data = wd;
      rd_en   = re;
      clr_err = ce;
      @(posedge clk);
      model_clock(we, wd, re, ce);
      #1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      clr_err = 1'b0;
      check_all();
   endtask

   task automatic do_reset();
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      clr_err = 1'b0;
      rst     = 1'b1;
      model_reset();
      #1;
      check_all();
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_all();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1);
   end

   initial begin
      int wr_n, rd_n, cyc;
      logic we, re;

      vecs[0]  = '{1'b1, 16'h0011, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0011, 1'b0, 16'h0000};
      vecs[1]  = '{1'b1, 16'h0022, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0011, 1'b0, 16'h0000};
      vecs[2]  = '{1'b1, 16'h0033, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0011, 1'b0, 16'h0000};
      vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0022, 1'b1, 16'h0011};
      vecs[4]  = '{1'b1, 16'h0044, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0033, 1'b1, 16'h0022};
      vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0044, 1'b1, 16'h0033};
      vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0044};
      vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0044};
      vecs[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0044};
      vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0044};
      vecs[10] = '{1'b1, 16'h0055, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0055, 1'b0, 16'h0044};
      vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0055, 1'b0, 16'h0044};

      #1 rst = 1'b1;
      #3;
      do_reset();

      // Table-driven vectors from a fresh reset.
      for (int i = 0; i < 12; i++) begin
         step(vecs[i].we, vecs[i].wd, vecs[i].re, vecs[i].ce);
         chk($sformatf("vec%0d_level", i), if_ft.level, vecs[i].lvl);
         chk($sformatf("vec%0d_aempty", i), if_rr.almost_empty, vecs[i].ae);
         chk($sformatf("vec%0d_overflow", i), if_ft.overflow, vecs[i].ovf);
         chk($sformatf("vec%0d_underflow", i), if_rr.underflow, vecs[i].unf);
         if (vecs[i].ft_chk) chk($sformatf("vec%0d_ft_data", i), if_ft.rd_data, vecs[i].ft_data);
         chk($sformatf("vec%0d_rr_valid", i), if_rr.rd_valid, vecs[i].rv);
         chk($sformatf("vec%0d_rr_data", i), if_rr.rd_data, vecs[i].rr_data);
      end

      // Fill to full, overflow on a 17th write, drain in order.
      do_reset();
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, DW'(i), 1'b0, 1'b0);
         chk("fill_almost_full", if_ft.almost_full, i >= 12);
      end
      chk("fill_full", if_ft.full, 1'b1);
      step(1'b1, 16'hFFFF, 1'b0, 1'b0);
      chk("ovf_set", if_ft.overflow, 1'b1);
      chk("ovf_level", if_ft.level, 16);
      for (int i = 1; i <= 16; i++) begin
         chk("drain_head", if_ft.rd_data, i);
         step(1'b0, '0, 1'b1, 1'b0);
         chk("drain_rr_data", if_rr.rd_data, i);
      end
      chk("drain_empty", if_ft.empty, 1'b1);

      // Registered read latency and underflow.
      do_reset();
      step(1'b1, 16'hA5A5, 1'b0, 1'b0);
      chk("rr_no_valid_before_read", if_rr.rd_valid, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("rr_valid_after_read", if_rr.rd_valid, 1'b1);
      chk("rr_data_after_read", if_rr.rd_data, 16'hA5A5);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("rr_underflow", if_rr.underflow, 1'b1);
      chk("rr_valid_on_underflow", if_rr.rd_valid, 1'b0);

      // Simultaneous read/write at level 5, then at full.
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, DW'(16'h0100 + i), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, DW'(16'h0200 + i), 1'b1, 1'b0);
         chk("both_level5", if_ft.level, 5);
      end
      for (int i = 0; i < 11; i++) step(1'b1, DW'(16'h0300 + i), 1'b0, 1'b0);
      chk("both_full", if_ft.full, 1'b1);
      step(1'b1, 16'hDEAD, 1'b1, 1'b0);
      chk("both_at_full_level", if_ft.level, 15);
      chk("both_at_full_ovf", if_ft.overflow, 1'b1);

      // Wrap-around: 40 interleaved words.
      do_reset();
      wr_n = 0;
      rd_n = 0;
      cyc  = 0;
      while (rd_n < 40 && cyc < 400) begin
         we = (wr_n < 40) && ($urandom_range(0, 3) != 0);
         re = ($urandom_range(0, 2) != 0);
         if (we && m_q.size() < D) wr_n++;
         if (re && m_q.size() != 0) rd_n++;
         step(we, DW'(16'h1000 + wr_n), re, 1'b0);
         cyc++;
      end
      chk("wrap_all_read", rd_n, 40);

      // Threshold steps 0 -> 3 -> 12 -> 11.
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
      chk("thr3_aempty", if_ft.almost_empty, 1'b0);
      chk("thr3_afull", if_ft.almost_full, 1'b0);
      for (int i = 0; i < 9; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
      chk("thr12_afull", if_ft.almost_full, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("thr11_afull", if_ft.almost_full, 1'b0);
      chk("thr11_aempty", if_ft.almost_empty, 1'b0);

      // Asynchronous reset in the middle of a write at level 7.
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b1, DW'(16'h0700 + i), 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      wr_en   = 1'b1;
      wr_data = 16'hBEEF;
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_all();
      chk("async_rst_level", if_ft.level, 0);
      chk("async_rst_rr_valid", if_rr.rd_valid, 1'b0);
      @(posedge clk);
      #1;
      rst   = 1'b0;
      wr_en = 1'b0;
      check_all();
      step(1'b1, 16'h1234, 1'b0, 1'b0);
      chk("post_rst_ft_data", if_ft.rd_data, 16'h1234);
      step(1'b0, '0, 1'b1, 1'b0);
      chk("post_rst_rr_data", if_rr.rd_data, 16'h1234);

      // Clear while a new overflow is raised: set wins.
      for (int i = 0; i < 16; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
      step(1'b1, 16'hFFFF, 1'b0, 1'b0);
      step(1'b1, 16'hFFFF, 1'b0, 1'b1);
      chk("clr_vs_set_ovf", if_ft.overflow, 1'b1);
      step(1'b0, '0, 1'b0, 1'b1);
      chk("clr_ovf", if_ft.overflow, 1'b0);

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 1) == 1, DW'($urandom), $urandom_range(0, 1) == 1,
              $urandom_range(0, 15) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
